spi_slave_regs: RTL and testbench

SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

---
 rtl/spi_slave_regs.sv | 166 ++++++++++++++++
 tb/tb_spi_slave_regs.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode-0 slave exposing a 16x8 register file, with a local host port.
// Rev 1.0
`default_nettype none

module spi_slave_regs #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_spi_sck,
  input  logic       i_spi_csn,
  input  logic       i_spi_mosi,
  output logic       o_spi_miso,
  output logic       o_spi_miso_oe,
  input  logic [3:0] i_host_addr,
  input  logic       i_host_we,
  input  logic [7:0] i_host_wdata,
  output logic [7:0] o_host_rdata,
  output logic       o_wr_stb,
  output logic [3:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_frame_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_csn_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_csn_d;
  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_rx;
  logic [7:0]             r_tx;
  logic                   r_tx_hold;
  logic                   r_write;
  logic [3:0]             r_addr;
  logic                   r_wr_stb;
  logic [3:0]             r_wr_addr;
  logic [7:0]             r_wr_data;
  logic                   r_frame_done;
  logic [7:0]             r_regs [16];

  logic       w_sck_s;
  logic       w_csn_s;
  logic       w_mosi_s;
  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_csn_fall;
  logic       w_byte_done;
  logic [7:0] w_rx_next;
  logic       w_spi_we;

  assign w_sck_s     = r_sck_sync[SYNC_STAGES-1];
  assign w_csn_s     = r_csn_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise  = w_sck_s & ~r_sck_d;
  assign w_sck_fall  = ~w_sck_s & r_sck_d;
  assign w_csn_fall  = ~w_csn_s & r_csn_d;
  assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);
  assign w_rx_next   = {r_rx, w_mosi_s};
  assign w_spi_we    = (r_state == S_DATA) && !w_csn_s && w_byte_done && r_write;

  assign o_spi_miso    = r_tx[7];
  assign o_spi_miso_oe = (r_state != S_IDLE);
  assign o_host_rdata  = r_regs[i_host_addr];
  assign o_wr_stb      = r_wr_stb;
  assign o_wr_addr     = r_wr_addr;
  assign o_wr_data     = r_wr_data;
  assign o_frame_done  = r_frame_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sck_sync  <= '0;
      r_csn_sync  <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_csn_d     <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_spi_sck};
      r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], i_spi_csn};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      r_sck_d     <= w_sck_s;
      r_csn_d     <= w_csn_s;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= 3'd0;
      r_rx         <= 7'd0;
      r_tx         <= 8'd0;
      r_tx_hold    <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= 4'd0;
      r_wr_stb     <= 1'b0;
      r_wr_addr    <= 4'd0;
      r_wr_data    <= 8'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_wr_stb     <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_csn_fall) begin
            r_state   <= S_CMD;
            r_bit_cnt <= 3'd0;
            r_tx      <= STATUS_BYTE;
            r_tx_hold <= 1'b0;
          end
        end
        default: begin
          if (w_csn_s) begin
            // Any partial byte is simply dropped here.
            r_state      <= S_IDLE;
            r_frame_done <= 1'b1;
          end else if (w_sck_rise) begin
            r_rx      <= w_rx_next[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done) begin
              r_tx_hold <= 1'b1;
              if (r_state == S_CMD) begin
                r_state <= S_DATA;
                r_write <= w_rx_next[7];
                r_addr  <= w_rx_next[3:0];
                r_tx    <= r_regs[w_rx_next[3:0]];
              end else begin
                r_addr <= r_addr + 4'd1;
                r_tx   <= r_regs[r_addr + 4'd1];
                if (r_write) begin
                  r_wr_stb  <= 1'b1;
                  r_wr_addr <= r_addr;
                  r_wr_data <= w_rx_next;
                end
              end
            end
          end else if (w_sck_fall) begin
            // The falling edge right after a byte load keeps bit7 on the line.
            if (r_tx_hold) r_tx_hold <= 1'b0;
            else           r_tx      <= {r_tx[6:0], 1'b0};
          end
        end
      endcase
    end
  end

  // SPI write is applied after the host write so it wins on an address clash.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= 8'd0;
    end else begin
      if (i_host_we) r_regs[i_host_addr] <= i_host_wdata;
      if (w_spi_we)  r_regs[r_addr]      <= w_rx_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_regs.sv
// tb_spi_slave_regs: frame-level reference model and per-cycle compare for spi_slave_regs.
`default_nettype none

module tb_spi_slave_regs;

  localparam int         SYNC = 2;
  localparam logic [7:0] STAT = 8'hA5;
  localparam int         HALF = 8;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       csn = 1'b1;
  logic       mosi = 1'b0;
  logic [3:0] host_addr = 4'd0;
  logic       host_we = 1'b0;
  logic [7:0] host_wdata = 8'd0;
  logic       miso, miso_oe, wr_stb, frame_done;
  logic [3:0] wr_addr;
  logic [7:0] wr_data, host_rdata;

  int         errors = 0;
  int         checks = 0;
  int         fd_seen = 0;
  int         fd_exp = 0;
  bit         quiet = 1'b0;
  logic [7:0] mreg [16];
  logic [7:0] fbytes [$];
  wr_t        exp_wr [$];

  always #5 clk = ~clk;

  spi_slave_regs #(.SYNC_STAGES(SYNC), .STATUS_BYTE(STAT)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_spi_sck    (sck),
    .i_spi_csn    (csn),
    .i_spi_mosi   (mosi),
    .o_spi_miso   (miso),
    .o_spi_miso_oe(miso_oe),
    .i_host_addr  (host_addr),
    .i_host_we    (host_we),
    .i_host_wdata (host_wdata),
    .o_host_rdata (host_rdata),
    .o_wr_stb     (wr_stb),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_frame_done (frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, sampled just after the active edge.
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (rst_n) begin
      if (wr_stb) begin
        if (exp_wr.size() == 0) chk("unexpected_wr_stb", 32'd1, 32'd0);
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.a));
          chk("wr_data", 32'(wr_data), 32'(e.d));
        end
      end
      if (frame_done) fd_seen++;
      if (quiet) chk("host_rdata", 32'(host_rdata), 32'(mreg[host_addr]));
    end
  end

  task automatic read_chk(input logic [3:0] a, input logic [7:0] exp, input string name);
    @(negedge clk);
    host_addr = a;
    #1;
    chk(name, 32'(host_rdata), 32'(exp));
  endtask

  task automatic check_regs();
    for (int i = 0; i < 16; i++) read_chk(4'(i), mreg[i], "regfile_sweep");
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    quiet = 1'b0;
    @(negedge clk);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    mreg[a] = d;
    quiet = 1'b1;
  endtask

  // Mode 0 master: mosi changes while sck low, miso sampled just before the rising edge.
  task automatic send_bits(input logic [7:0] b, input int nb, input bit exp_wr_now,
                           input bit coll, output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 0; i < nb; i++) begin
      mosi = b[7-i];
      repeat (HALF) @(negedge clk);
      rx = {rx[6:0], miso};
      sck = 1'b1;
      if (i == 7) begin
        repeat (SYNC) @(negedge clk);
        if (coll) begin
          host_addr = 4'd7; host_wdata = 8'h55; host_we = 1'b1;
        end
        @(negedge clk);
        host_we = 1'b0;
        if (exp_wr_now) chk("wr_stb_timing", 32'(wr_stb), 32'd1);
        repeat (HALF - SYNC - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      sck = 1'b0;
    end
  endtask

  // One frame: command byte then fbytes; last_bits < 8 aborts inside the last byte.
  task automatic spi_frame(input logic [7:0] cmd, input int last_bits, input bit coll);
    logic [7:0] em [$];
    logic [7:0] rx;
    logic [3:0] a;
    int         n, nfull, nb;
    n     = fbytes.size();
    nfull = (last_bits == 8) ? n : n - 1;
    quiet = 1'b0;
    em.push_back(STAT);
    a = cmd[3:0];
    for (int k = 0; k < n; k++) begin
      em.push_back(mreg[a]);
      a = a + 4'd1;
    end
    a = cmd[3:0];
    if (cmd[7]) for (int k = 0; k < nfull; k++) begin
      exp_wr.push_back(wr_t'{a, fbytes[k]});
      a = a + 4'd1;
    end
    @(negedge clk);
    csn = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("miso_oe_active", 32'(miso_oe), 32'd1);
    send_bits(cmd, 8, 1'b0, 1'b0, rx);
    chk("miso_status", 32'(rx), 32'(STAT));
    for (int k = 0; k < n; k++) begin
      nb = (k == n - 1) ? last_bits : 8;
      send_bits(fbytes[k], nb, cmd[7] && (nb == 8), coll && (k == n - 1), rx);
      if (nb == 8) chk("miso_data", 32'(rx), 32'(em[k+1]));
    end
    repeat (HALF) @(negedge clk);
    csn = 1'b1;
    fd_exp++;
    repeat (SYNC + 3) @(negedge clk);
    chk("frame_done_count", 32'(fd_seen), 32'(fd_exp));
    chk("miso_oe_idle", 32'(miso_oe), 32'd0);
    chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    a = cmd[3:0];
    if (cmd[7]) for (int k = 0; k < nfull; k++) begin
      mreg[a] = fbytes[k];
      a = a + 4'd1;
    end
    quiet = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rx, cmd;
    int         n, lb;
    for (int i = 0; i < 16; i++) mreg[i] = 8'd0;

    repeat (3) @(negedge clk);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_miso_oe", 32'(miso_oe), 32'd0);
    chk("rst_wr_stb", 32'(wr_stb), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_host_rdata", 32'(host_rdata), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    quiet = 1'b1;
    check_regs();

    // sck activity with csn high must be ignored.
    for (int i = 0; i < 10; i++) begin
      sck = ~sck;
      repeat (HALF) @(negedge clk);
    end
    sck = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("idle_sck_no_frame", 32'(fd_seen), 32'd0);

    fbytes = '{8'h11, 8'h22};
    spi_frame(8'h83, 8, 1'b0);
    read_chk(4'd3, 8'h11, "write_reg3");
    read_chk(4'd4, 8'h22, "write_reg4");

    fbytes = '{8'($urandom), 8'($urandom)};
    spi_frame(8'h03, 8, 1'b0);

    fbytes = '{8'hAA, 8'hBB};
    spi_frame(8'h8F, 8, 1'b0);
    read_chk(4'd15, 8'hAA, "wrap_reg15");
    read_chk(4'd0, 8'hBB, "wrap_reg0");

    fbytes = '{8'h77};
    spi_frame(8'h85, 4, 1'b0);
    read_chk(4'd5, 8'h00, "abort_reg5");

    fbytes = '{8'h66};
    spi_frame(8'h87, 8, 1'b1);
    read_chk(4'd7, 8'h66, "collision_reg7");

    for (int f = 0; f < 16; f++) begin
      cmd = 8'($urandom);
      n   = $urandom_range(1, 3);
      lb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
      fbytes.delete();
      for (int k = 0; k < n; k++) fbytes.push_back(8'($urandom));
      spi_frame(cmd, lb, 1'b0);
      if ($urandom_range(0, 1) == 1) host_write(4'($urandom), 8'($urandom));
    end
    check_regs();

    // Reset in the middle of a write data byte.
    quiet = 1'b0;
    @(negedge clk);
    csn = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(8'h82, 8, 1'b0, 1'b0, rx);
    send_bits(8'h3C, 5, 1'b0, 1'b0, rx);
    rst_n = 1'b0;
    csn = 1'b1; sck = 1'b0; mosi = 1'b0;
    for (int i = 0; i < 16; i++) mreg[i] = 8'd0;
    repeat (3) @(negedge clk);
    chk("midrst_miso_oe", 32'(miso_oe), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    fbytes = '{8'h9C};
    spi_frame(8'h81, 8, 1'b0);
    read_chk(4'd1, 8'h9C, "post_reset_reg1");
    read_chk(4'd2, 8'h00, "post_reset_reg2");
    check_regs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
